uart_rx: RTL

UART serial receiver. It pairs with the team's baud timing generator and UART transmitter on the far end of the link. It runs on the system clock with its own 16x oversampling tick. It finds the start bit, samples each bit at mid-point, checks framing, and hands each received byte to the fabric through a single-entry valid/ready register.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_os_tick.sv | 44 ++++
 rtl/uart_rx.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: line state encoding used by both receiver and
// transmitter, plus the oversampling ratio and divider helper.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_e;

  function automatic int os_div(input int sysclk_rate, input int baud_rate);
    return sysclk_rate / (baud_rate * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversampling tick generator: one-cycle pulse every OS_DIV system clocks,
// restartable so the first tick of a frame lands a full period after clr_i.
module uart_os_tick
  import uart_pkg::*;
#(
  parameter int SYSCLK_RATE = 100000000,
  parameter int BAUD_RATE   = 9600
) (
  input  logic SysClk,
  input  logic Rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int OS_DIV = os_div(SYSCLK_RATE, BAUD_RATE);
  localparam int CW     = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(OS_DIV - 1);

  if (OS_DIV < 1) begin : g_bad_div
    $error("uart_os_tick: SYSCLK_RATE too low for 16x oversampling of BAUD_RATE");
  end

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || (cnt_q == CNT_MAX)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge SysClk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling and a single-entry valid/ready buffer.
// Define UART_RX_PARITY_EN to expect an even-parity bit after the data bits.
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYSCLK_RATE = 100000000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8
) (
  input  logic                 SysClk,
  input  logic                 Rst_n,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] Data,
  output logic                 Valid,
  input  logic                 Ready,
  output logic                 FrameErr,
  output logic                 ParityErr,
  output logic                 Overrun
);

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [3:0]    MID_CNT  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]    LAST_CNT = 4'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_bad_bits
    $error("uart_rx: DATA_BITS must be in 5..8");
  end

  uart_state_e         state_q, state_d;
  logic                sync1_q, rxs_q, rxs_prev_q;
  logic [3:0]          tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]       bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                fe_q, fe_d;
  logic                ov_q, ov_d;
  logic                os_tick, os_clr;
  logic                rx_fall;
  logic                stop_good, stop_bad;
  logic                par_ok;

  assign rx_fall = rxs_prev_q & ~rxs_q;

  uart_os_tick #(
    .SYSCLK_RATE (SYSCLK_RATE),
    .BAUD_RATE   (BAUD_RATE)
  ) u_os_tick (
    .SysClk (SysClk),
    .Rst_n  (Rst_n),
    .clr_i  (os_clr),
    .tick_o (os_tick)
  );

  // Synchronizer resets to the idle-high level so reset release is not seen as a start edge.
  always_ff @(posedge SysClk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= Rx;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic pe_q, pe_d;

  assign par_ok    = ~((^shift_q) ^ par_q);
  assign ParityErr = pe_q;

  always_ff @(posedge SysClk or negedge Rst_n) begin
    if (!Rst_n) begin
      par_q <= 1'b0;
      pe_q  <= 1'b0;
    end else begin
      par_q <= par_d;
      pe_q  <= pe_d;
    end
  end
`else
  assign par_ok    = 1'b1;
  assign ParityErr = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    os_clr     = 1'b0;
    stop_good  = 1'b0;
    stop_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (rx_fall) begin
          state_d    = START;
          tick_cnt_d = '0;
          os_clr     = 1'b1;
        end
      end
      START: begin
        if (os_tick) begin
          if (tick_cnt_q == MID_CNT) begin
            tick_cnt_d = '0;
            bit_idx_d  = '0;
            state_d    = rxs_q ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (os_tick) begin
          if (tick_cnt_q == LAST_CNT) begin
            tick_cnt_d         = '0;
            shift_d[bit_idx_q] = rxs_q;
            if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (os_tick) begin
          if (tick_cnt_q == LAST_CNT) begin
            tick_cnt_d = '0;
            par_d      = rxs_q;
            state_d    = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (os_tick) begin
          if (tick_cnt_q == LAST_CNT) begin
            tick_cnt_d = '0;
            if (rxs_q) begin
              stop_good = 1'b1;
              state_d   = IDLE;
            end else begin
              stop_bad = 1'b1;
              state_d  = BREAK;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      BREAK: begin
        if (rxs_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A byte that fails parity or arrives while the buffer is held is dropped; the held byte survives.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = stop_bad;
    ov_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe_d    = stop_good & ~par_ok;
`endif
    if (valid_q && Ready) begin
      valid_d = 1'b0;
    end
    if (stop_good && par_ok) begin
      if (valid_q && !Ready) begin
        ov_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge SysClk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      fe_q       <= 1'b0;
      ov_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      fe_q       <= fe_d;
      ov_q       <= ov_d;
    end
  end

  assign Data     = data_q;
  assign Valid    = valid_q;
  assign FrameErr = fe_q;
  assign Overrun  = ov_q;

endmodule
